// File: rtl/fetch_bundle_emitter_pkg.sv
//==============================================================================
// Package : fetch_pkg
// Shared widths, bundle-length encoding and emitter state encoding for the
// fetch->decode bundle path.
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_pkg;

  localparam int INSTR_WIDTH   = 32;
  localparam int BUNDLE_SLOTS  = 4;
  localparam int BUNDLE_WIDTH  = BUNDLE_SLOTS * INSTR_WIDTH;
  localparam int LINE_WORDS    = 16;
  localparam int ADDRESS_WIDTH = 64;
  localparam int PID_SIZE      = 32;
  localparam int TID_SIZE      = 64;
  localparam int MAJID_WIDTH   = 64;

  // Bundle length travels as instruction count minus one.
  typedef logic [1:0] bundle_len_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } emit_state_t;

  function automatic bundle_len_t encode_len(input logic [2:0] count);
    return bundle_len_t'(count - 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_bundle_emitter_if.sv
//==============================================================================
// Interface : fetch_bundle_if
// Bundle bus from the emitter (master) to the bundle parser (slave).
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

interface fetch_bundle_if #(
  parameter int ADDRESS_WIDTH = fetch_pkg::ADDRESS_WIDTH,
  parameter int PID_SIZE      = fetch_pkg::PID_SIZE,
  parameter int TID_SIZE      = fetch_pkg::TID_SIZE
);

  logic                              enable_o;
  logic [fetch_pkg::BUNDLE_WIDTH-1:0] bundle_o;
  logic [ADDRESS_WIDTH-1:0]          bundleAddress_o;
  fetch_pkg::bundle_len_t            bundleLen_o;
  logic                              is64Bit_o;
  logic [PID_SIZE-1:0]               bundlePid_o;
  logic [TID_SIZE-1:0]               bundleTid_o;
  logic [fetch_pkg::MAJID_WIDTH-1:0] bundleStartMajId_o;
  logic                              downstreamReady_i;

  modport master (
    output enable_o, bundle_o, bundleAddress_o, bundleLen_o,
    output is64Bit_o, bundlePid_o, bundleTid_o, bundleStartMajId_o,
    input  downstreamReady_i
  );

  modport slave (
    input  enable_o, bundle_o, bundleAddress_o, bundleLen_o,
    input  is64Bit_o, bundlePid_o, bundleTid_o, bundleStartMajId_o,
    output downstreamReady_i
  );

endinterface

`default_nettype wire

// File: rtl/fetch_bundle_emitter_packer.sv
//==============================================================================
// Module : fetch_bundle_packer
// Combinational slicer: buffered line + cursor -> zero-filled 4-slot bundle,
// instruction count, and a flag marking the final bundle of the line.
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_bundle_packer
  import fetch_pkg::*;
#(
  parameter int LINE_WORDS   = fetch_pkg::LINE_WORDS,
  parameter int CURSOR_WIDTH = $clog2(LINE_WORDS)
) (
  input  wire logic [LINE_WORDS*INSTR_WIDTH-1:0] line_i,
  input  wire logic [CURSOR_WIDTH-1:0]           cursor_i,
  output logic      [BUNDLE_WIDTH-1:0]           bundle_o,
  output logic      [2:0]                        count_o,
  output logic                                   last_o
);

  localparam int c_REM_WIDTH = CURSOR_WIDTH + 1;

  logic [c_REM_WIDTH-1:0] w_remaining;

  assign w_remaining = c_REM_WIDTH'(LINE_WORDS) - {1'b0, cursor_i};
  assign last_o      = (w_remaining <= c_REM_WIDTH'(BUNDLE_SLOTS));
  assign count_o     = last_o ? 3'(w_remaining) : 3'(BUNDLE_SLOTS);

  // Slots past the end of the line stay zero; bundles never wrap into word 0.
  always_comb begin
    bundle_o = '0;
    for (int k = 0; k < BUNDLE_SLOTS; k++) begin
      for (int j = 0; j < LINE_WORDS; j++) begin
        if ((k < int'(count_o)) && (j == int'(cursor_i) + k)) begin
          bundle_o[k*INSTR_WIDTH +: INSTR_WIDTH] = line_i[j*INSTR_WIDTH +: INSTR_WIDTH];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_bundle_emitter.sv
//==============================================================================
// Module : fetch_bundle_emitter
// Buffers one fetched I-cache line and emits it as bundles of up to four
// instructions, tagging each with its starting major ID.
// Optional: FETCH_BUNDLE_PERF_EN adds saturating bundle/stall counters.
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_bundle_emitter
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = fetch_pkg::ADDRESS_WIDTH,
  parameter int LINE_WORDS    = fetch_pkg::LINE_WORDS,
  parameter int PID_SIZE      = fetch_pkg::PID_SIZE,
  parameter int TID_SIZE      = fetch_pkg::TID_SIZE
) (
  input  wire logic                              clock_i,
  input  wire logic                              reset_i,
  input  wire logic                              lineValid_i,
  output logic                                   lineReady_o,
  input  wire logic [LINE_WORDS*INSTR_WIDTH-1:0] line_i,
  input  wire logic [ADDRESS_WIDTH-1:0]          fetchAddress_i,
  input  wire logic                              is64Bit_i,
  input  wire logic [PID_SIZE-1:0]               pid_i,
  input  wire logic [TID_SIZE-1:0]               tid_i,
  input  wire logic                              flush_i,
  fetch_bundle_if.master                         bundle_if
`ifdef FETCH_BUNDLE_PERF_EN
  ,
  output logic [31:0]                            bundleCount_o,
  output logic [31:0]                            stallCount_o
`endif
);

  localparam int c_CURSOR_WIDTH = $clog2(LINE_WORDS);
  localparam int c_OFFSET_BITS  = c_CURSOR_WIDTH + 2;
  localparam logic [ADDRESS_WIDTH-1:0] c_BASE_MASK = {ADDRESS_WIDTH{1'b1}} << c_OFFSET_BITS;

  emit_state_t                      r_state;
  logic [LINE_WORDS*INSTR_WIDTH-1:0] r_line;
  logic [c_CURSOR_WIDTH-1:0]        r_cursor;
  logic [ADDRESS_WIDTH-1:0]         r_base;
  logic                             r_is64;
  logic [PID_SIZE-1:0]              r_pid;
  logic [TID_SIZE-1:0]              r_tid;
  logic [MAJID_WIDTH-1:0]           r_majId;

  logic                             r_enable;
  logic [BUNDLE_WIDTH-1:0]          r_bundle;
  logic [ADDRESS_WIDTH-1:0]         r_bundleAddress;
  bundle_len_t                      r_bundleLen;
  logic                             r_outIs64;
  logic [PID_SIZE-1:0]              r_outPid;
  logic [TID_SIZE-1:0]              r_outTid;
  logic [MAJID_WIDTH-1:0]           r_startMajId;

  logic [BUNDLE_WIDTH-1:0]          w_bundle;
  logic [2:0]                       w_count;
  logic                             w_last;
  logic                             w_emit;
  logic                             w_accept;

  fetch_bundle_packer #(
    .LINE_WORDS   (LINE_WORDS),
    .CURSOR_WIDTH (c_CURSOR_WIDTH)
  ) u_packer (
    .line_i   (r_line),
    .cursor_i (r_cursor),
    .bundle_o (w_bundle),
    .count_o  (w_count),
    .last_o   (w_last)
  );

  assign w_emit = (r_state == ST_EMIT) && bundle_if.downstreamReady_i && !flush_i;

  // Ready on the final bundle's cycle lets the next line follow with no bubble.
  assign lineReady_o = !flush_i &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_EMIT) && bundle_if.downstreamReady_i && w_last));
  assign w_accept    = lineValid_i && lineReady_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state         <= ST_IDLE;
      r_line          <= '0;
      r_cursor        <= '0;
      r_base          <= '0;
      r_is64          <= 1'b0;
      r_pid           <= '0;
      r_tid           <= '0;
      r_majId         <= '0;
      r_enable        <= 1'b0;
      r_bundle        <= '0;
      r_bundleAddress <= '0;
      r_bundleLen     <= '0;
      r_outIs64       <= 1'b0;
      r_outPid        <= '0;
      r_outTid        <= '0;
      r_startMajId    <= '0;
    end else if (flush_i) begin
      r_state  <= ST_IDLE;
      r_enable <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      if (w_emit) begin
        r_enable        <= 1'b1;
        r_bundle        <= w_bundle;
        r_bundleAddress <= r_base + (ADDRESS_WIDTH'(r_cursor) << 2);
        r_bundleLen     <= encode_len(w_count);
        r_outIs64       <= r_is64;
        r_outPid        <= r_pid;
        r_outTid        <= r_tid;
        r_startMajId    <= r_majId;
        r_cursor        <= r_cursor + c_CURSOR_WIDTH'(w_count);
        r_majId         <= r_majId + MAJID_WIDTH'(w_count);
      end
      if (w_accept) begin
        r_state  <= ST_EMIT;
        r_line   <= line_i;
        r_base   <= fetchAddress_i & c_BASE_MASK;
        r_cursor <= fetchAddress_i[c_OFFSET_BITS-1:2];
        r_is64   <= is64Bit_i;
        r_pid    <= pid_i;
        r_tid    <= tid_i;
      end else if (w_emit && w_last) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign bundle_if.enable_o           = r_enable;
  assign bundle_if.bundle_o           = r_bundle;
  assign bundle_if.bundleAddress_o    = r_bundleAddress;
  assign bundle_if.bundleLen_o        = r_bundleLen;
  assign bundle_if.is64Bit_o          = r_outIs64;
  assign bundle_if.bundlePid_o        = r_outPid;
  assign bundle_if.bundleTid_o        = r_outTid;
  assign bundle_if.bundleStartMajId_o = r_startMajId;

`ifdef FETCH_BUNDLE_PERF_EN
  logic [31:0] r_bundleCount;
  logic [31:0] r_stallCount;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_bundleCount <= '0;
      r_stallCount  <= '0;
    end else begin
      if (w_emit && (r_bundleCount != '1)) begin
        r_bundleCount <= r_bundleCount + 32'd1;
      end
      if ((r_state == ST_EMIT) && !bundle_if.downstreamReady_i && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + 32'd1;
      end
    end
  end

  assign bundleCount_o = r_bundleCount;
  assign stallCount_o  = r_stallCount;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_bundle_emitter.sv
//==============================================================================
// Module : tb_fetch_bundle_emitter
// Self-checking bench for fetch_bundle_emitter with a queue-based bundle model.
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_bundle_emitter;
  import fetch_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic [63:0]  addr;
    logic [1:0]   len;
    logic [2:0]   n;
    logic         is64;
    logic [31:0]  pid;
    logic [63:0]  tid;
  } bundle_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         lineValid;
  logic         lineReady;
  logic [511:0] line;
  logic [63:0]  pc;
  logic         is64;
  logic [31:0]  pid;
  logic [63:0]  tid;
  logic         flush;

  int tests = 0;
  int fails = 0;

  bundle_t     q[$];
  bundle_t     m_last;
  logic [63:0] m_cnt;
  logic [63:0] m_lastMaj;
  logic        exp_en;
  logic        exp_ready;
  logic        obs_ready;

  fetch_bundle_if bif ();

  fetch_bundle_emitter dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .lineValid_i    (lineValid),
    .lineReady_o    (lineReady),
    .line_i         (line),
    .fetchAddress_i (pc),
    .is64Bit_i      (is64),
    .pid_i          (pid),
    .tid_i          (tid),
    .flush_i        (flush),
    .bundle_if      (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Slice a line into its bundle sequence straight from the addressing rules.
  task automatic model_load(input logic [63:0] a, input logic [511:0] l, input logic m,
                            input logic [31:0] p, input logic [63:0] t);
    bundle_t b;
    int c;
    c = int'(a[5:2]);
    while (c < 16) begin
      b.n    = (16 - c >= 4) ? 3'd4 : 3'(16 - c);
      b.data = '0;
      for (int k = 0; k < int'(b.n); k++) b.data[k*32 +: 32] = l[(c+k)*32 +: 32];
      b.addr = (a & ~64'h3f) + 64'(c * 4);
      b.len  = 2'(b.n - 3'd1);
      b.is64 = m;
      b.pid  = p;
      b.tid  = t;
      q.push_back(b);
      c += int'(b.n);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] a, input logic [511:0] l, input logic m,
                      input logic [31:0] p, input logic [63:0] t, input logic f, input logic r);
    lineValid = v; pc = a; line = l; is64 = m; pid = p; tid = t; flush = f;
    bif.downstreamReady_i = r;
    @(negedge clk);
    obs_ready = lineReady;
    exp_ready = !f && ((q.size() == 0) || (r && q.size() == 1));
    exp_en    = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (q.size() > 0 && r) begin
        m_last    = q.pop_front();
        m_lastMaj = m_cnt;
        m_cnt     = m_cnt + 64'(m_last.n);
        exp_en    = 1'b1;
      end
      if (v && exp_ready) model_load(a, l, m, p, t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lineValid = 1'b0; flush = 1'b0; pc = '0; line = '0;
    is64 = 1'b0; pid = '0; tid = '0; bif.downstreamReady_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_cnt = '0; m_lastMaj = '0; exp_en = 1'b0;
    m_last = '{default: '0};
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL reset_enable: got %b expected 0", bif.enable_o); end
    tests++; if (bif.bundle_o !== '0) begin fails++; $display("FAIL reset_bundle: got %h expected 0", bif.bundle_o); end
    tests++; if (bif.bundleAddress_o !== '0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bif.bundleAddress_o); end
    tests++; if (bif.bundleLen_o !== 2'd0) begin fails++; $display("FAIL reset_len: got %0d expected 0", bif.bundleLen_o); end
    tests++; if (bif.bundleStartMajId_o !== '0) begin fails++; $display("FAIL reset_majid: got %h expected 0", bif.bundleStartMajId_o); end
    tests++; if ({bif.is64Bit_o, bif.bundlePid_o, bif.bundleTid_o} !== '0) begin fails++; $display("FAIL reset_owner: got %h expected 0", {bif.is64Bit_o, bif.bundlePid_o, bif.bundleTid_o}); end
    tests++; if (lineReady !== 1'b1) begin fails++; $display("FAIL reset_lineready: got %b expected 1", lineReady); end
  endtask

  task automatic test_aligned_line();
    logic [511:0] l;
    l = rand_line();
    step(1'b1, 64'h1000, l, 1'b1, 32'hA5A5, 64'h77, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL aligned_latency: got %b expected 0", bif.enable_o); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      tests++; if (bif.enable_o !== 1'b1) begin fails++; $display("FAIL aligned_en%0d: got %b expected 1", i, bif.enable_o); end
      tests++; if (bif.bundleLen_o !== 2'd3) begin fails++; $display("FAIL aligned_len%0d: got %0d expected 3", i, bif.bundleLen_o); end
      tests++; if (bif.bundleAddress_o !== 64'h1000 + 64'(16*i)) begin fails++; $display("FAIL aligned_addr%0d: got %h expected %h", i, bif.bundleAddress_o, 64'h1000 + 64'(16*i)); end
      tests++; if (bif.bundleStartMajId_o !== 64'(4*i)) begin fails++; $display("FAIL aligned_majid%0d: got %0d expected %0d", i, bif.bundleStartMajId_o, 4*i); end
      tests++; if (bif.bundle_o !== l[i*128 +: 128]) begin fails++; $display("FAIL aligned_data%0d: got %h expected %h", i, bif.bundle_o, l[i*128 +: 128]); end
      tests++; if ({bif.is64Bit_o, bif.bundlePid_o, bif.bundleTid_o} !== {1'b1, 32'hA5A5, 64'h77}) begin fails++; $display("FAIL aligned_owner%0d: got %h", i, {bif.is64Bit_o, bif.bundlePid_o, bif.bundleTid_o}); end
    end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL aligned_done: got %b expected 0", bif.enable_o); end
    tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL aligned_idle_ready: got %b expected 1", obs_ready); end
  endtask

  task automatic test_partial_line();
    logic [511:0] l;
    l = rand_line();
    step(1'b1, 64'h1034, l, 1'b0, 32'h3, 64'h4, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b1) begin fails++; $display("FAIL partial_en: got %b expected 1", bif.enable_o); end
    tests++; if (bif.bundleLen_o !== 2'd2) begin fails++; $display("FAIL partial_len: got %0d expected 2", bif.bundleLen_o); end
    tests++; if (bif.bundleAddress_o !== 64'h1034) begin fails++; $display("FAIL partial_addr: got %h expected 1034", bif.bundleAddress_o); end
    tests++; if (bif.bundle_o !== {32'h0, l[15*32 +: 32], l[14*32 +: 32], l[13*32 +: 32]}) begin fails++; $display("FAIL partial_data: got %h expected %h", bif.bundle_o, {32'h0, l[15*32 +: 32], l[14*32 +: 32], l[13*32 +: 32]}); end
    tests++; if (bif.bundleStartMajId_o !== 64'd16) begin fails++; $display("FAIL partial_majid: got %0d expected 16", bif.bundleStartMajId_o); end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL partial_done: got %b expected 0", bif.enable_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, 64'h1000, rand_line(), 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL stall_en%0d: got %b expected 0", i, bif.enable_o); end
      tests++; if (bif.bundleAddress_o !== 64'h1000) begin fails++; $display("FAIL stall_hold%0d: got %h expected 1000", i, bif.bundleAddress_o); end
    end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b1) begin fails++; $display("FAIL stall_resume_en: got %b expected 1", bif.enable_o); end
    tests++; if (bif.bundleAddress_o !== 64'h1010) begin fails++; $display("FAIL stall_resume_addr: got %h expected 1010", bif.bundleAddress_o); end
    tests++; if (bif.bundleStartMajId_o !== 64'd4) begin fails++; $display("FAIL stall_resume_majid: got %0d expected 4", bif.bundleStartMajId_o); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 64'h1000, rand_line(), 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h2000, rand_line(), 1'b0, '0, '0, 1'b1, 1'b1);
    tests++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", obs_ready); end
    tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL flush_en: got %b expected 0", bif.enable_o); end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b0) begin fails++; $display("FAIL flush_idle_en: got %b expected 0", bif.enable_o); end
    tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL flush_idle_ready: got %b expected 1", obs_ready); end
    step(1'b1, 64'h2000, rand_line(), 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.bundleAddress_o !== 64'h2000) begin fails++; $display("FAIL flush_next_addr: got %h expected 2000", bif.bundleAddress_o); end
    tests++; if (bif.bundleStartMajId_o !== 64'd4) begin fails++; $display("FAIL flush_next_majid: got %0d expected 4", bif.bundleStartMajId_o); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] l2;
    l2 = rand_line();
    do_reset();
    step(1'b1, 64'h1020, rand_line(), 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h3000, l2, 1'b1, 32'h9, 64'h9, 1'b0, 1'b1);
    tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b expected 1", obs_ready); end
    tests++; if (bif.bundleAddress_o !== 64'h1030 || bif.enable_o !== 1'b1) begin fails++; $display("FAIL b2b_last: got en %b addr %h expected en 1 addr 1030", bif.enable_o, bif.bundleAddress_o); end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tests++; if (bif.enable_o !== 1'b1) begin fails++; $display("FAIL b2b_gap: got %b expected 1", bif.enable_o); end
    tests++; if (bif.bundleAddress_o !== 64'h3000) begin fails++; $display("FAIL b2b_addr: got %h expected 3000", bif.bundleAddress_o); end
    tests++; if (bif.bundleStartMajId_o !== 64'd8) begin fails++; $display("FAIL b2b_majid: got %0d expected 8", bif.bundleStartMajId_o); end
    tests++; if (bif.bundle_o !== l2[127:0]) begin fails++; $display("FAIL b2b_data: got %h expected %h", bif.bundle_o, l2[127:0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), {48'h0, 16'($urandom)} & ~64'h3, rand_line(),
           1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready@%0d: got %b expected %b", i, obs_ready, exp_ready); end
      tests++; if (bif.enable_o !== exp_en) begin fails++; $display("FAIL rnd_en@%0d: got %b expected %b", i, bif.enable_o, exp_en); end
      tests++; if (bif.bundle_o !== m_last.data) begin fails++; $display("FAIL rnd_data@%0d: got %h expected %h", i, bif.bundle_o, m_last.data); end
      tests++; if ({bif.bundleAddress_o, bif.bundleLen_o} !== {m_last.addr, m_last.len}) begin fails++; $display("FAIL rnd_addrlen@%0d: got %h/%0d expected %h/%0d", i, bif.bundleAddress_o, bif.bundleLen_o, m_last.addr, m_last.len); end
      tests++; if (bif.bundleStartMajId_o !== m_lastMaj) begin fails++; $display("FAIL rnd_majid@%0d: got %0d expected %0d", i, bif.bundleStartMajId_o, m_lastMaj); end
      tests++; if ({bif.is64Bit_o, bif.bundlePid_o, bif.bundleTid_o} !== {m_last.is64, m_last.pid, m_last.tid}) begin fails++; $display("FAIL rnd_owner@%0d: got %h expected %h", i, {bif.is64Bit_o, bif.bundlePid_o, bif.bundleTid_o}, {m_last.is64, m_last.pid, m_last.tid}); end
    end
  endtask

  initial begin
    test_reset();
    test_aligned_line();
    test_partial_line();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
